// File: rtl/mem_controller_mc_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and helpers for the multi-channel memory controller.
//   chan_state_e : per-channel FSM state encoding
//   idx_width()  : width of a consumer index; at least 1 bit even for 1 consumer
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAITING  = 2'b01,
        ST_RELAYING = 2'b10
    } chan_state_e;

    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_controller_mc_if.sv
// -----------------------------------------------------------------------------
// mem_controller_mc_if
// Bundles the consumer (LSU) side and the memory side of the controller.
//   consumer_read_*  / consumer_write_* : per-consumer request/response
//   mem_read_*       / mem_write_*      : per-channel memory port
// Modports:
//   slave  : the controller (receives consumer requests, drives memory)
//   master : the environment (drives consumer requests and memory responses)
// -----------------------------------------------------------------------------
interface mem_controller_mc_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

endinterface

// File: rtl/mem_controller_mc_rr.sv
// -----------------------------------------------------------------------------
// rr_multi_grant
// Combinational multi-grant round-robin arbiter. Idle channels, in ascending
// index order, each take a distinct pending consumer, searching consumers
// circularly from i_rr_ptr.
//   i_pending     : consumers requesting and not owned by any channel
//   i_idle        : channels able to accept a consumer this cycle
//   i_rr_ptr      : first consumer index to consider
//   o_grant_valid : per-channel grant flag
//   o_grant_idx   : per-channel granted consumer index
//   o_next_ptr    : last granted consumer + 1 (wrapping); i_rr_ptr if none
// -----------------------------------------------------------------------------
module rr_multi_grant
    import mem_ctrl_pkg::*;
#(
    parameter  int NUM_CONSUMERS = 4,
    parameter  int NUM_CHANNELS  = 1,
    localparam int IW            = idx_width(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0]         i_pending,
    input  logic [NUM_CHANNELS-1:0]          i_idle,
    input  logic [IW-1:0]                    i_rr_ptr,
    output logic [NUM_CHANNELS-1:0]          o_grant_valid,
    output logic [NUM_CHANNELS-1:0][IW-1:0]  o_grant_idx,
    output logic [IW-1:0]                    o_next_ptr
);

    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [IW:0]              w_sum;
    logic [IW-1:0]            w_cand;
    logic                     w_hit;

    // Walk channels in order; each claims the first free pending consumer
    // after the pointer. w_taken keeps one consumer from going to two channels.
    always_comb begin
        w_taken       = '0;
        o_grant_valid = '0;
        o_grant_idx   = '0;
        o_next_ptr    = i_rr_ptr;
        w_sum         = '0;
        w_cand        = '0;
        w_hit         = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                w_sum  = {1'b0, i_rr_ptr} + (IW+1)'(k);
                w_cand = (w_sum >= (IW+1)'(NUM_CONSUMERS)) ?
                         IW'(w_sum - (IW+1)'(NUM_CONSUMERS)) : IW'(w_sum);
                w_hit  = i_idle[ch] & ~o_grant_valid[ch] &
                         i_pending[w_cand] & ~w_taken[w_cand];
                o_grant_valid[ch] = o_grant_valid[ch] | w_hit;
                o_grant_idx[ch]   = w_hit ? w_cand : o_grant_idx[ch];
                w_taken[w_cand]   = w_taken[w_cand] | w_hit;
                o_next_ptr        = w_hit ?
                                    ((w_cand == IW'(NUM_CONSUMERS - 1)) ? '0 : w_cand + IW'(1)) :
                                    o_next_ptr;
            end
        end
    end

endmodule

// File: rtl/mem_controller_mc.sv
// -----------------------------------------------------------------------------
// mem_controller_mc
// Multi-channel memory controller between per-thread LSUs and external memory
// ports. Each channel owns one consumer at a time and runs IDLE -> WAITING ->
// RELAYING; a shared round-robin arbiter hands pending consumers to idle
// channels.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : mem_controller_mc_if.slave (consumer requests, memory ports)
// WRITE_ENABLE = 0 builds a read-only controller: write-only requests are never
// granted and all write outputs are tied low.
// -----------------------------------------------------------------------------
module mem_controller_mc
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_controller_mc_if.slave  bus
);

    localparam int IW = idx_width(NUM_CONSUMERS);

    // Per-channel state
    chan_state_e [NUM_CHANNELS-1:0]          r_state;
    logic [NUM_CHANNELS-1:0][IW-1:0]         r_owner;
    logic [NUM_CHANNELS-1:0]                 r_is_read;
    logic [NUM_CHANNELS-1:0]                 r_mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_read_addr;
    logic [NUM_CHANNELS-1:0]                 r_mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_write_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  r_mem_write_data;

    // Per-consumer ownership and response registers
    logic [NUM_CONSUMERS-1:0]                r_owned;
    logic [NUM_CONSUMERS-1:0]                r_resp_valid;
    logic [NUM_CONSUMERS-1:0]                r_resp_is_read;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_resp_data;
    logic [IW-1:0]                           r_rr_ptr;

    logic [NUM_CONSUMERS-1:0]                w_pending;
    logic [NUM_CONSUMERS-1:0]                w_write_req;
    logic [NUM_CHANNELS-1:0]                 w_idle;
    logic [NUM_CHANNELS-1:0]                 w_grant_valid;
    logic [NUM_CHANNELS-1:0][IW-1:0]         w_grant_idx;
    logic [IW-1:0]                           w_next_ptr;

    // A read-only build never treats a write request as pending.
    assign w_write_req = (WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0;
    assign w_pending   = (bus.consumer_read_valid | w_write_req) & ~r_owned;

    // Idle flags feeding the arbiter.
    always_comb begin
        w_idle = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_idle[ch] = (r_state[ch] == ST_IDLE);
        end
    end

    rr_multi_grant #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .NUM_CHANNELS  (NUM_CHANNELS)
    ) u_rr (
        .i_pending     (w_pending),
        .i_idle        (w_idle),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx),
        .o_next_ptr    (w_next_ptr)
    );

    // Channel FSMs, ownership table, response registers and arbiter pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= {NUM_CHANNELS{ST_IDLE}};
            r_owner           <= '0;
            r_is_read         <= '0;
            r_mem_read_valid  <= '0;
            r_mem_read_addr   <= '0;
            r_mem_write_valid <= '0;
            r_mem_write_addr  <= '0;
            r_mem_write_data  <= '0;
            r_owned           <= '0;
            r_resp_valid      <= '0;
            r_resp_is_read    <= '0;
            r_resp_data       <= '0;
            r_rr_ptr          <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (r_state[ch])
                    ST_IDLE: begin
                        if (w_grant_valid[ch]) begin
                            r_owner[ch]                <= w_grant_idx[ch];
                            r_owned[w_grant_idx[ch]]   <= 1'b1;
                            r_state[ch]                <= ST_WAITING;
                            // Read takes priority when a consumer raises both.
                            if (bus.consumer_read_valid[w_grant_idx[ch]]) begin
                                r_is_read[ch]        <= 1'b1;
                                r_mem_read_valid[ch] <= 1'b1;
                                r_mem_read_addr[ch]  <= bus.consumer_read_address[w_grant_idx[ch]];
                            end else begin
                                r_is_read[ch]         <= 1'b0;
                                r_mem_write_valid[ch] <= 1'b1;
                                r_mem_write_addr[ch]  <= bus.consumer_write_address[w_grant_idx[ch]];
                                r_mem_write_data[ch]  <= bus.consumer_write_data[w_grant_idx[ch]];
                            end
                        end
                    end
                    ST_WAITING: begin
                        // Memory transaction always completes, even if the consumer gave up.
                        if (r_is_read[ch]) begin
                            if (bus.mem_read_ready[ch]) begin
                                r_mem_read_valid[ch]        <= 1'b0;
                                r_resp_valid[r_owner[ch]]   <= 1'b1;
                                r_resp_is_read[r_owner[ch]] <= 1'b1;
                                r_resp_data[r_owner[ch]]    <= bus.mem_read_data[ch];
                                r_state[ch]                 <= ST_RELAYING;
                            end
                        end else begin
                            if (bus.mem_write_ready[ch]) begin
                                r_mem_write_valid[ch]       <= 1'b0;
                                r_resp_valid[r_owner[ch]]   <= 1'b1;
                                r_resp_is_read[r_owner[ch]] <= 1'b0;
                                r_state[ch]                 <= ST_RELAYING;
                            end
                        end
                    end
                    ST_RELAYING: begin
                        if (!bus.consumer_read_valid[r_owner[ch]] &&
                            !bus.consumer_write_valid[r_owner[ch]]) begin
                            r_resp_valid[r_owner[ch]] <= 1'b0;
                            r_owned[r_owner[ch]]      <= 1'b0;
                            r_state[ch]               <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[ch] <= ST_IDLE;
                    end
                endcase
            end
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Ready follows the consumer's own valid so it drops the moment the
    // consumer lets go; the response direction keeps read and write apart.
    assign bus.consumer_read_ready  = r_resp_valid & r_resp_is_read & bus.consumer_read_valid;
    assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ?
                                      (r_resp_valid & ~r_resp_is_read & bus.consumer_write_valid) : '0;
    assign bus.consumer_read_data   = r_resp_data;

    assign bus.mem_read_valid    = r_mem_read_valid;
    assign bus.mem_read_address  = r_mem_read_addr;
    assign bus.mem_write_valid   = (WRITE_ENABLE != 0) ? r_mem_write_valid : '0;
    assign bus.mem_write_address = (WRITE_ENABLE != 0) ? r_mem_write_addr  : '0;
    assign bus.mem_write_data    = (WRITE_ENABLE != 0) ? r_mem_write_data  : '0;

endmodule

// File: tb/tb_mem_controller_mc.sv
// -----------------------------------------------------------------------------
// tb_mem_controller_mc
// Directed bench with two controller instances sharing one clock:
//   dut A : 4 consumers, 2 channels, writes enabled
//   dut B : 4 consumers, 1 channel, read-only
// -----------------------------------------------------------------------------
module tb_mem_controller_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_controller_mc_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) ia ();
    mem_controller_mc_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) ib ();

    mem_controller_mc #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia)
    );

    mem_controller_mc #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib)
    );

    int       n_checks = 0;
    int       n_fail   = 0;
    bit       auto_mem  = 1'b0;
    bit       auto_cons = 1'b0;
    int       done_a [4];
    int       rise_a [2];
    int       remain_b [4];
    bit       rearm_b [4];
    logic     prev_a [2];
    logic     prev_b;
    logic [7:0] grant_log_b [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Data the bench memory returns for a given address.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {~a, a};
    endfunction

    // One clock: re-arm consumers, log grants, run the zero-wait memory and
    // the consumers that drop valid as soon as ready is seen.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rearm_b[i]) begin
                ib.consumer_read_valid[i] = 1'b1;
                rearm_b[i] = 1'b0;
                remain_b[i]--;
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            if (ia.mem_read_valid[ch] && !prev_a[ch]) rise_a[ch]++;
            prev_a[ch] = ia.mem_read_valid[ch];
        end
        if (ib.mem_read_valid[0] && !prev_b) grant_log_b.push_back(ib.mem_read_address[0]);
        prev_b = ib.mem_read_valid[0];
        if (auto_mem) begin
            for (int ch = 0; ch < 2; ch++) begin
                ia.mem_read_ready[ch]  = ia.mem_read_valid[ch];
                ia.mem_read_data[ch]   = mem_word(ia.mem_read_address[ch]);
                ia.mem_write_ready[ch] = ia.mem_write_valid[ch];
            end
            ib.mem_read_ready[0] = ib.mem_read_valid[0];
            ib.mem_read_data[0]  = mem_word(ib.mem_read_address[0]);
        end
        if (auto_cons) begin
            for (int i = 0; i < 4; i++) begin
                if (ia.consumer_read_ready[i]) begin
                    check_eq($sformatf("a_rdata%0d", i), ia.consumer_read_data[i],
                             mem_word(ia.consumer_read_address[i]));
                    ia.consumer_read_valid[i] = 1'b0;
                    done_a[i]++;
                end
                if (ib.consumer_read_ready[i]) begin
                    check_eq($sformatf("b_rdata%0d", i), ib.consumer_read_data[i],
                             mem_word(ib.consumer_read_address[i]));
                    ib.consumer_read_valid[i] = 1'b0;
                    if (remain_b[i] > 0) rearm_b[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic quiesce_mem();
        auto_mem  = 1'b0;
        auto_cons = 1'b0;
        ia.mem_read_ready  = '0;
        ia.mem_write_ready = '0;
        ib.mem_read_ready  = '0;
        ib.mem_write_ready = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        ia.consumer_read_valid = '0;  ia.consumer_read_address = '0;
        ia.consumer_write_valid = '0; ia.consumer_write_address = '0; ia.consumer_write_data = '0;
        ia.mem_read_ready = '0; ia.mem_read_data = '0; ia.mem_write_ready = '0;
        ib.consumer_read_valid = '0;  ib.consumer_read_address = '0;
        ib.consumer_write_valid = '0; ib.consumer_write_address = '0; ib.consumer_write_data = '0;
        ib.mem_read_ready = '0; ib.mem_read_data = '0; ib.mem_write_ready = '0;
        for (int i = 0; i < 4; i++) begin
            done_a[i] = 0; remain_b[i] = 0; rearm_b[i] = 1'b0;
        end
        rise_a[0] = 0; rise_a[1] = 0; prev_a[0] = 1'b0; prev_a[1] = 1'b0; prev_b = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        step();

        // Reset state
        check_eq("rst_a_mrv",   ia.mem_read_valid, 32'h0);
        check_eq("rst_a_mwv",   ia.mem_write_valid, 32'h0);
        check_eq("rst_a_maddr", ia.mem_read_address, 32'h0);
        check_eq("rst_a_wdata", ia.mem_write_data, 32'h0);
        check_eq("rst_a_crdy",  ia.consumer_read_ready, 32'h0);
        check_eq("rst_a_cwrdy", ia.consumer_write_ready, 32'h0);
        check_eq("rst_b_mrv",   ib.mem_read_valid, 32'h0);
        check_eq("rst_b_rdata", ib.consumer_read_data, 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // B: consumer 2 reads 0x10, memory answers 0xBEEF two cycles later
        ib.consumer_read_address[2] = 8'h10;
        ib.consumer_read_valid[2]   = 1'b1;
        step();
        check_eq("b_t1_mrv",   ib.mem_read_valid, 32'h1);
        check_eq("b_t1_addr",  ib.mem_read_address[0], 32'h10);
        check_eq("b_t1_crdy0", ib.consumer_read_ready, 32'h0);
        step();
        check_eq("b_t1_wait",  ib.mem_read_valid, 32'h1);
        check_eq("b_t1_crdy1", ib.consumer_read_ready, 32'h0);
        ib.mem_read_ready[0] = 1'b1;
        ib.mem_read_data[0]  = 16'hBEEF;
        step();
        check_eq("b_t1_mrv_drop", ib.mem_read_valid, 32'h0);
        check_eq("b_t1_crdy2",    ib.consumer_read_ready, 32'h4);
        check_eq("b_t1_data",     ib.consumer_read_data[2], 32'hBEEF);
        ib.mem_read_ready[0] = 1'b0;
        ib.mem_read_data[0]  = 16'h0000;
        step();
        check_eq("b_t1_hold_rdy",  ib.consumer_read_ready, 32'h4);
        check_eq("b_t1_hold_data", ib.consumer_read_data[2], 32'hBEEF);
        ib.consumer_read_valid[2] = 1'b0;
        #1;
        check_eq("b_t1_rdy_drop", ib.consumer_read_ready, 32'h0);
        step();
        // Channel is idle again: a fresh request is granted on the next edge
        ib.consumer_read_address[2] = 8'h11;
        ib.consumer_read_valid[2]   = 1'b1;
        auto_mem  = 1'b1;
        auto_cons = 1'b1;
        step();
        check_eq("b_t1_regrant", ib.mem_read_valid, 32'h1);
        check_eq("b_t1_readdr",  ib.mem_read_address[0], 32'h11);
        step();
        step();
        quiesce_mem();

        // B read-only: a write-only request is never granted
        ib.consumer_write_address[1] = 8'h22;
        ib.consumer_write_data[1]    = 16'h1234;
        ib.consumer_write_valid[1]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("b_ro_mwv%0d", k), ib.mem_write_valid, 32'h0);
            check_eq($sformatf("b_ro_mrv%0d", k), ib.mem_read_valid, 32'h0);
            check_eq($sformatf("b_ro_wrdy%0d", k), ib.consumer_write_ready, 32'h0);
        end
        ib.consumer_read_address[3] = 8'h13;
        ib.consumer_read_valid[3]   = 1'b1;
        auto_mem  = 1'b1;
        auto_cons = 1'b1;
        step();
        check_eq("b_ro_rd_grant", ib.mem_read_address[0], 32'h13);
        step();
        step();
        quiesce_mem();
        ib.consumer_write_valid[1] = 1'b0;
        check_eq("b_ro_rd_done", ib.consumer_read_valid, 32'h0);

        // B fairness: consumer 0 keeps re-requesting while consumer 3 waits
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        grant_log_b.delete();
        for (int i = 0; i < 4; i++) ib.consumer_read_address[i] = 8'h30 + 8'(i);
        remain_b[0] = 2;
        remain_b[3] = 1;
        ib.consumer_read_valid[0] = 1'b1;
        ib.consumer_read_valid[3] = 1'b1;
        auto_mem  = 1'b1;
        auto_cons = 1'b1;
        repeat (20) step();
        quiesce_mem();
        check_eq("b_fair_count", grant_log_b.size(), 32'd5);
        if (grant_log_b.size() == 5) begin
            check_eq("b_fair_g0", grant_log_b[0], 32'h30);
            check_eq("b_fair_g1", grant_log_b[1], 32'h33);
            check_eq("b_fair_g2", grant_log_b[2], 32'h30);
            check_eq("b_fair_g3", grant_log_b[3], 32'h33);
            check_eq("b_fair_g4", grant_log_b[4], 32'h30);
        end

        // A: all four consumers read at once over two channels
        for (int i = 0; i < 4; i++) ia.consumer_read_address[i] = 8'h40 + 8'(i);
        ia.consumer_read_valid = 4'b1111;
        auto_mem  = 1'b1;
        auto_cons = 1'b1;
        step();
        check_eq("a_t2_mrv_first", ia.mem_read_valid, 32'h3);
        check_eq("a_t2_ch0_first", ia.mem_read_address[0], 32'h40);
        check_eq("a_t2_ch1_first", ia.mem_read_address[1], 32'h41);
        step();
        step();
        step();
        check_eq("a_t2_mrv_second", ia.mem_read_valid, 32'h3);
        check_eq("a_t2_ch0_second", ia.mem_read_address[0], 32'h42);
        check_eq("a_t2_ch1_second", ia.mem_read_address[1], 32'h43);
        step();
        step();
        step();
        quiesce_mem();
        for (int i = 0; i < 4; i++) check_eq($sformatf("a_t2_done%0d", i), done_a[i], 32'd1);
        check_eq("a_t2_rise0", rise_a[0], 32'd2);
        check_eq("a_t2_rise1", rise_a[1], 32'd2);

        // A: consumer 1 writes 0x1234 to 0x22
        ia.consumer_write_address[1] = 8'h22;
        ia.consumer_write_data[1]    = 16'h1234;
        ia.consumer_write_valid[1]   = 1'b1;
        step();
        check_eq("a_wr_mwv",   ia.mem_write_valid, 32'h1);
        check_eq("a_wr_addr",  ia.mem_write_address[0], 32'h22);
        check_eq("a_wr_data",  ia.mem_write_data[0], 32'h1234);
        check_eq("a_wr_mrv",   ia.mem_read_valid, 32'h0);
        check_eq("a_wr_rdy0",  ia.consumer_write_ready, 32'h0);
        ia.mem_write_ready[0] = 1'b1;
        step();
        check_eq("a_wr_mwv_drop", ia.mem_write_valid, 32'h0);
        check_eq("a_wr_rdy",      ia.consumer_write_ready, 32'h2);
        check_eq("a_wr_rrdy",     ia.consumer_read_ready, 32'h0);
        ia.mem_write_ready[0]     = 1'b0;
        ia.consumer_write_valid[1] = 1'b0;
        #1;
        check_eq("a_wr_rdy_drop", ia.consumer_write_ready, 32'h0);
        step();

        // A: consumer 0 raises read and write together -> read path
        ia.consumer_read_address[0]  = 8'h55;
        ia.consumer_write_address[0] = 8'h66;
        ia.consumer_write_data[0]    = 16'h7777;
        ia.consumer_read_valid[0]    = 1'b1;
        ia.consumer_write_valid[0]   = 1'b1;
        step();
        check_eq("a_rw_mrv",  ia.mem_read_valid, 32'h1);
        check_eq("a_rw_addr", ia.mem_read_address[0], 32'h55);
        check_eq("a_rw_mwv",  ia.mem_write_valid, 32'h0);
        ia.mem_read_ready[0] = 1'b1;
        ia.mem_read_data[0]  = 16'h0A0A;
        step();
        check_eq("a_rw_rrdy", ia.consumer_read_ready, 32'h1);
        check_eq("a_rw_wrdy", ia.consumer_write_ready, 32'h0);
        check_eq("a_rw_data", ia.consumer_read_data[0], 32'h0A0A);
        check_eq("a_rw_mwv2", ia.mem_write_valid, 32'h0);
        ia.mem_read_ready[0]       = 1'b0;
        ia.consumer_read_valid[0]  = 1'b0;
        ia.consumer_write_valid[0] = 1'b0;
        step();
        step();

        // A: reset while a channel waits on memory, then a fresh start
        ia.consumer_read_address[1] = 8'h71;
        ia.consumer_read_valid[1]   = 1'b1;
        step();
        check_eq("a_rst_waiting", ia.mem_read_valid, 32'h1);
        step();
        rst_a = 1'b1;
        ia.consumer_read_address[3] = 8'h73;
        ia.consumer_read_valid[3]   = 1'b1;
        step();
        check_eq("a_rst_mrv",   ia.mem_read_valid, 32'h0);
        check_eq("a_rst_mwv",   ia.mem_write_valid, 32'h0);
        check_eq("a_rst_crdy",  ia.consumer_read_ready, 32'h0);
        check_eq("a_rst_maddr", ia.mem_read_address, 32'h0);
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) done_a[i] = 0;
        auto_mem  = 1'b1;
        auto_cons = 1'b1;
        step();
        check_eq("a_post_mrv", ia.mem_read_valid, 32'h3);
        check_eq("a_post_ch0", ia.mem_read_address[0], 32'h71);
        check_eq("a_post_ch1", ia.mem_read_address[1], 32'h73);
        step();
        step();
        quiesce_mem();
        check_eq("a_post_done1", done_a[1], 32'd1);
        check_eq("a_post_done3", done_a[3], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_controller_mc.md
Name: mem_controller_mc

Overview:
- Multi-channel successor to the single-channel memory controller; sits between the per-thread LSUs (consumers) and the external memory ports.
- Serves up to NUM_CHANNELS consumer requests concurrently. Each memory channel owns one consumer at a time and runs its own IDLE/WAITING/RELAYING FSM.
- A shared round-robin arbiter assigns pending consumers to idle channels.
- Returns full-width read data and supports a read-only mode for program memory.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 16, memory data width
- NUM_CONSUMERS, 4, number of LSU consumers; must be >= 1
- NUM_CHANNELS, 1, number of concurrent memory channels; must satisfy 1 <= NUM_CHANNELS <= NUM_CONSUMERS
- WRITE_ENABLE, 1, 0 = read-only build: write logic removed, mem_write_valid tied 0, consumer_write_ready tied 0

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request; held until ready, then dropped
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read address per consumer
- consumer_read_ready  out  NUM_CONSUMERS  read complete; data valid while high
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  returned read data per consumer
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write address per consumer
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data per consumer
- consumer_write_ready  out  NUM_CONSUMERS  write complete
- mem_read_valid  out  NUM_CHANNELS  per-channel read request
- mem_read_address  out  NUM_CHANNELS x ADDR_BITS  per-channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read done
- mem_read_data  in  NUM_CHANNELS x DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  per-channel write request
- mem_write_address  out  NUM_CHANNELS x ADDR_BITS  per-channel write address
- mem_write_data  out  NUM_CHANNELS x DATA_BITS  per-channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- Reset (clk edge with reset=1):
  - All channels go to IDLE; all mem_* valid/address/data outputs = 0.
  - All response_valid = 0; all response_data = 0; ownership cleared; rr_ptr = 0.
  - consumer_*_ready = 0 combinationally from that edge.
  - Reset mid-transaction abandons it; memory sees valid drop the next cycle.
- Pending consumer: read_valid or write_valid is high and the consumer is not owned by any channel.
- Arbitration, each cycle:
  - Idle channels, taken in ascending channel index, are each granted a distinct pending consumer.
  - Consumers are searched in round-robin order starting at rr_ptr.
  - rr_ptr then becomes (last granted consumer + 1) mod NUM_CONSUMERS; it is unchanged if nothing is granted.
  - No consumer is ever owned by two channels.
- IDLE -> WAITING on grant (same edge):
  - If read_valid is set: mem_read_valid=1 and address latched.
  - Otherwise, write path: mem_write_valid=1 and address/data latched.
  - Read wins if both valids are high.
  - With WRITE_ENABLE=0, write-only requests are never granted.
- WAITING:
  - On mem_*_ready=1 for the active direction: drop mem_*_valid, set response_valid[owner], capture mem_read_data on reads, go to RELAYING.
  - No timeout.
- RELAYING:
  - consumer_read_ready[i] = response_valid[i] & consumer_read_valid[i]; write ready is analogous.
  - consumer_read_data[i] = response_data[i], full DATA_BITS, ungated.
  - When the owner has both valids low: clear response_valid, release ownership, go to IDLE.
  - The consumer can be re-granted no earlier than the cycle after the channel returns to IDLE.
- Latency:
  - Request sampled at edge N -> mem valid high after edge N.
  - mem ready at edge M -> consumer ready after M.
  - Minimum round trip is 3 cycles with zero-wait memory.
- Consumer valid dropped while WAITING: the memory transaction still completes; the channel then sees both valids low in RELAYING and returns to IDLE.
- NUM_CHANNELS=1 with NUM_CONSUMERS=1 degenerates to a single FSM; rr_ptr is constant 0.

Decomposition:
- Package mem_ctrl_pkg: channel state enum (IDLE=2'b00, WAITING=2'b01, RELAYING=2'b10); $clog2 helper for consumer index width.
- Sub-module rr_multi_grant: combinational multi-grant round-robin over pending[NUM_CONSUMERS] for idle[NUM_CHANNELS]; outputs per-channel grant_valid/grant_idx and next_ptr.
- Top level holds the channel FSM generate loop, ownership table and response registers.

Test Plan:
- NUM_CHANNELS=1, consumer 2 reads addr 0x10, memory returns 0xBEEF after 2 cycles -> mem_read_address=0x10; consumer_read_data[2]=0xBEEF (all 16 bits) with ready; idle after valid drops.
- NUM_CHANNELS=2, consumers 0..3 all read at once -> consumers 0,1 granted on the same edge; 2,3 granted as channels free; no consumer granted twice.
- Fairness: consumer 0 re-requests continuously with consumer 3 pending, 1 channel -> grant order alternates 0,3,0,3; rr_ptr wraps 3->0.
- Write addr 0x22 data 0x1234 from consumer 1 -> mem_write_* = 0x22/0x1234; write_ready after mem_write_ready; WRITE_ENABLE=0 -> never granted, mem_write_valid stays 0.
- Reset asserted during WAITING -> next edge all mem valids=0, ready outputs=0, rr_ptr=0; a fresh request completes normally afterwards.
- Simultaneous read and write valid on consumer 0 -> read path taken; mem_write_valid stays 0.
